// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and defaults for the bit-serial adder
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/Fa.sv
// rtl/Fa.sv - one-bit full adder shared by every bit position of the serial add
module Fa (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  assign sum   = a_in ^ b_in ^ c_in;
  assign carry = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - LSB-first serial adder sequencer around a single Fa
// Optional subtract mode (sub_in port) enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic             ready_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
  logic             fa_sum;
  logic             fa_carry;

  // Subtraction is a + ~b + 1, so only the captured B and carry-in differ.
`ifdef SERIAL_ADD_SUB_EN
  assign b_cap = sub_in ? ~b_in : b_in;
  assign c_cap = sub_in | c_in;
`else
  assign b_cap = b_in;
  assign c_cap = c_in;
`endif

  Fa u_fa (
    .a_in  (a_sh[0]),
    .b_in  (b_sh[0]),
    .c_in  (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      ready_out <= 1'b1;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_sh      <= a_in;
            b_sh      <= b_cap;
            carry_reg <= c_cap;
            cnt       <= '0;
            res_sh    <= '0;
            ready_out <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_sh    <= {fa_sum, res_sh[WIDTH-1:1]};
          carry_reg <= fa_carry;
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          // Hold the counter at terminal count so it never starts a second pass.
          if (cnt == LAST) begin
            sum_out   <= {fa_sum, res_sh[WIDTH-1:1]};
            carry_out <= fa_carry;
            done_out  <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
